// File: rtl/uart_rx.sv
// uart_rx: UART receiver, 8 data bits LSB first, one stop bit.
// Build option: define UART_RX_PARITY_EN to expect one even-parity bit
// between the data bits and the stop bit.
//
// Parameters:
//   CLK_PER_BIT    clock cycles per serial bit (>= 4)
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   serial         asynchronous serial line, idle high
//   data[7:0]      last correctly received byte, held until the next good byte
//   data_valid     one-cycle pulse, data is new in the same cycle
//   framing_error  one-cycle pulse when the stop bit is sampled low
//   parity_error   one-cycle pulse on parity mismatch (constant 0 without parity)
module uart_rx #(
  parameter int unsigned CLK_PER_BIT = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       serial,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       framing_error,
  output logic       parity_error
);

  localparam int unsigned CW = $clog2(CLK_PER_BIT) + 1;
  localparam logic [CW-1:0] C_LAST = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF = CW'(CLK_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t          r_state, w_state_n;
  logic [CW-1:0]   r_cnt, w_cnt_n;
  logic [2:0]      r_bit, w_bit_n;
  logic [7:0]      r_shift, w_shift_n;
  logic            r_sync1, r_rx_s;
  logic            w_valid, w_ferr;
`ifdef UART_RX_PARITY_EN
  logic            r_par, w_par_n;
  logic            w_perr;
  logic            r_perr;
`endif

  // Two-flop synchronizer; reset to the idle (high) level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= serial;
      r_rx_s  <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
`ifdef UART_RX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_bit   <= w_bit_n;
      r_shift <= w_shift_n;
`ifdef UART_RX_PARITY_EN
      r_par   <= w_par_n;
`endif
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt + 1'b1;
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_valid   = 1'b0;
    w_ferr    = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_n   = r_par;
    w_perr    = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        w_cnt_n = '0;
        if (!r_rx_s) w_state_n = S_START;
      end
      S_START: begin
        // Mid-start-bit recheck rejects short glitches on an idle line.
        if (r_cnt == C_HALF) begin
          w_cnt_n = '0;
          if (!r_rx_s) begin
            w_state_n = S_DATA;
            w_bit_n   = '0;
          end else begin
            w_state_n = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (r_cnt == C_LAST) begin
          w_cnt_n          = '0;
          w_shift_n[r_bit] = r_rx_s;
          if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_n = S_PARITY;
`else
            w_state_n = S_STOP;
`endif
          end else begin
            w_bit_n = r_bit + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (r_cnt == C_LAST) begin
          w_cnt_n   = '0;
          w_par_n   = r_rx_s;
          w_state_n = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (r_cnt == C_LAST) begin
          w_cnt_n = '0;
          if (r_rx_s) begin
            w_state_n = S_IDLE;
`ifdef UART_RX_PARITY_EN
            // Even parity: data bits plus parity bit must XOR to zero.
            if (^{r_shift, r_par}) w_perr  = 1'b1;
            else                   w_valid = 1'b1;
`else
            w_valid = 1'b1;
`endif
          end else begin
            // Framing error wins over parity; wait out a held-low line.
            w_ferr    = 1'b1;
            w_state_n = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        w_cnt_n = '0;
        if (r_rx_s) w_state_n = S_IDLE;
      end
      default: begin
        w_cnt_n   = '0;
        w_state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data          <= '0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      data_valid    <= w_valid;
      framing_error <= w_ferr;
      if (w_valid) data <= r_shift;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_perr <= 1'b0;
    else        r_perr <= w_perr;
  end
  assign parity_error = r_perr;
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
  localparam int CPB = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       serial = 1'b1;
  logic [7:0] data;
  logic       data_valid, framing_error, parity_error;

  uart_rx #(.CLK_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .serial(serial), .data(data),
    .data_valid(data_valid), .framing_error(framing_error),
    .parity_error(parity_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_valid = 0, n_ferr = 0, n_perr = 0, n_multi = 0, valid_cyc = 0;
  logic [7:0] d_last = 8'h00, d_prev = 8'h00;
  always @(negedge clk) begin
    if (data_valid) begin
      n_valid++;
      d_prev = d_last;
      d_last = data;
      valid_cyc = cyc;
    end
    if (framing_error) n_ferr++;
    if (parity_error) n_perr++;
    if (int'(data_valid) + int'(framing_error) + int'(parity_error) > 1) n_multi++;
  end

  int n_checks = 0, n_fail = 0;
  int stop_cyc = 0;
`ifdef UART_RX_PARITY_EN
  logic tx_par_flip = 1'b0;
`endif

  // Called at a negedge; returns at a negedge at the end of the stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    serial = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serial = b[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    serial = (^b) ^ tx_par_flip;
    repeat (CPB) @(negedge clk);
`endif
    serial = stop;
    stop_cyc = cyc;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h expected 00", data); end
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b expected 0", data_valid); end
    n_checks++; if (framing_error !== 1'b0) begin n_fail++; $display("FAIL reset_ferr got %b expected 0", framing_error); end
    n_checks++; if (parity_error !== 1'b0) begin n_fail++; $display("FAIL reset_perr got %b expected 0", parity_error); end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_basic;
    int bv, bf, bp;
    bv = n_valid; bf = n_ferr; bp = n_perr;
    send_frame(8'hA5, 1'b1);
    repeat (2 * CPB) @(negedge clk);
    n_checks++; if (n_valid - bv !== 1) begin n_fail++; $display("FAIL basic_count got %0d expected 1", n_valid - bv); end
    n_checks++; if (data !== 8'hA5) begin n_fail++; $display("FAIL basic_data got %h expected a5", data); end
    n_checks++; if (n_ferr - bf + n_perr - bp !== 0) begin n_fail++; $display("FAIL basic_err got %0d expected 0", n_ferr - bf + n_perr - bp); end
    // 2 synchronizer stages + output register + half bit from stop-bit start.
    n_checks++; if (valid_cyc - stop_cyc !== 3 + CPB / 2) begin n_fail++; $display("FAIL basic_latency got %0d expected %0d", valid_cyc - stop_cyc, 3 + CPB / 2); end
  endtask

  task automatic test_back_to_back;
    int bv, bf;
    bv = n_valid; bf = n_ferr;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (2 * CPB) @(negedge clk);
    n_checks++; if (n_valid - bv !== 2) begin n_fail++; $display("FAIL b2b_count got %0d expected 2", n_valid - bv); end
    n_checks++; if (d_prev !== 8'h00) begin n_fail++; $display("FAIL b2b_first got %h expected 00", d_prev); end
    n_checks++; if (d_last !== 8'hFF) begin n_fail++; $display("FAIL b2b_second got %h expected ff", d_last); end
    n_checks++; if (n_ferr - bf !== 0) begin n_fail++; $display("FAIL b2b_ferr got %0d expected 0", n_ferr - bf); end
  endtask

  task automatic test_glitch;
    int bv, bf, bp;
    bv = n_valid; bf = n_ferr; bp = n_perr;
    serial = 1'b0;
    repeat (30) @(negedge clk);
    serial = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    n_checks++; if (n_valid - bv !== 0) begin n_fail++; $display("FAIL glitch_valid got %0d expected 0", n_valid - bv); end
    n_checks++; if (n_ferr - bf + n_perr - bp !== 0) begin n_fail++; $display("FAIL glitch_err got %0d expected 0", n_ferr - bf + n_perr - bp); end
    send_frame(8'h3C, 1'b1);
    repeat (2 * CPB) @(negedge clk);
    n_checks++; if (n_valid - bv !== 1) begin n_fail++; $display("FAIL glitch_next_count got %0d expected 1", n_valid - bv); end
    n_checks++; if (data !== 8'h3C) begin n_fail++; $display("FAIL glitch_next_data got %h expected 3c", data); end
  endtask

  task automatic test_framing;
    int bv, bf;
    bv = n_valid; bf = n_ferr;
    send_frame(8'h55, 1'b0);
    repeat (5 * CPB) @(negedge clk);
    serial = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    n_checks++; if (n_ferr - bf !== 1) begin n_fail++; $display("FAIL frame_ferr got %0d expected 1", n_ferr - bf); end
    n_checks++; if (n_valid - bv !== 0) begin n_fail++; $display("FAIL frame_valid got %0d expected 0", n_valid - bv); end
    n_checks++; if (data !== 8'h3C) begin n_fail++; $display("FAIL frame_hold got %h expected 3c", data); end
    send_frame(8'h12, 1'b1);
    repeat (2 * CPB) @(negedge clk);
    n_checks++; if (n_valid - bv !== 1) begin n_fail++; $display("FAIL frame_next_count got %0d expected 1", n_valid - bv); end
    n_checks++; if (data !== 8'h12) begin n_fail++; $display("FAIL frame_next_data got %h expected 12", data); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int bv, bp;
    bv = n_valid; bp = n_perr;
    tx_par_flip = 1'b0;
    send_frame(8'h07, 1'b1);
    repeat (2 * CPB) @(negedge clk);
    n_checks++; if (n_valid - bv !== 1) begin n_fail++; $display("FAIL par_good_count got %0d expected 1", n_valid - bv); end
    n_checks++; if (data !== 8'h07) begin n_fail++; $display("FAIL par_good_data got %h expected 07", data); end
    tx_par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    tx_par_flip = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    n_checks++; if (n_perr - bp !== 1) begin n_fail++; $display("FAIL par_bad_perr got %0d expected 1", n_perr - bp); end
    n_checks++; if (n_valid - bv !== 1) begin n_fail++; $display("FAIL par_bad_valid got %0d expected 1", n_valid - bv); end
    n_checks++; if (data !== 8'h07) begin n_fail++; $display("FAIL par_bad_data got %h expected 07", data); end
  endtask
`endif

  task automatic test_reset_midframe;
    int bv, bf, bp;
    logic [7:0] b;
    bv = n_valid; bf = n_ferr; bp = n_perr;
    b = 8'hC3;
    serial = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      serial = b[i];
      repeat (CPB) @(negedge clk);
    end
    serial = b[4];
    repeat (CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    serial = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL rstmid_in_reset got %h expected 00", data); end
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    n_checks++; if (n_valid - bv + n_ferr - bf + n_perr - bp !== 0) begin n_fail++; $display("FAIL rstmid_pulses got %0d expected 0", n_valid - bv + n_ferr - bf + n_perr - bp); end
    n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL rstmid_data got %h expected 00", data); end
    send_frame(8'h81, 1'b1);
    repeat (2 * CPB) @(negedge clk);
    n_checks++; if (n_valid - bv !== 1) begin n_fail++; $display("FAIL rstmid_next_count got %0d expected 1", n_valid - bv); end
    n_checks++; if (data !== 8'h81) begin n_fail++; $display("FAIL rstmid_next_data got %h expected 81", data); end
  endtask

  task automatic test_exclusive;
    n_checks++; if (n_multi !== 0) begin n_fail++; $display("FAIL exclusive got %0d cycles expected 0", n_multi); end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_basic;
    test_back_to_back;
    test_glitch;
    test_framing;
`ifdef UART_RX_PARITY_EN
    test_parity;
`endif
    test_reset_midframe;
    test_exclusive;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
